// File: rtl/instr_loader.sv
// instr_loader: receive side of the CPU instruction-write port.
// Packs a stream of 32-bit words into a word-addressed instruction RAM while
// holding the core in LOAD, then releases it (RUN) and serves registered
// fetch reads. Fetches at or beyond the loaded length return NOP.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous reset, active-low
//   wr_instr_en_i  write strobe, one word per high cycle in LOAD
//   wr_instr_i     instruction word to write
//   reload_i       single-cycle pulse: discard program, re-enter LOAD
//   pc_i           fetch byte address (bits [1:0] ignored)
//   instr_o        fetched instruction, registered
//   cpu_run_o      high in RUN; core stalls while low
//   instr_count_o  words accepted in the current load
//   overflow_o     sticky: write attempted while RAM full
module instr_loader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_instr_en_i,
  input  logic [31:0]   wr_instr_i,
  input  logic          reload_i,
  input  logic [31:0]   pc_i,
  output logic [31:0]   instr_o,
  output logic          cpu_run_o,
  output logic [AW:0]   instr_count_o,
  output logic          overflow_o
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        mem_we;
  logic [31:0] instr_q, instr_d;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] fetch_addr;
  logic          fetch_ok;

  // State, count and overflow registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_LOAD;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic; reload takes priority over any strobe in the same cycle
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (reload_i) begin
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (wr_instr_en_i) begin
          if (count_q < DEPTH_C) begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
            // Accepting the final word fills the RAM: leave LOAD immediately
            if (count_q == LAST_C) state_d = S_RUN;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (count_q != '0) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (reload_i) begin
          state_d    = S_LOAD;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Instruction RAM write port (contents not reset)
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[count_q[AW-1:0]] <= wr_instr_i;
  end

  // Fetch qualification: in RUN, upper pc bits clear, word inside loaded range
  assign fetch_addr = pc_i[AW+1:2];
  assign fetch_ok   = (state_q == S_RUN) &&
                      ((pc_i >> (AW + 2)) == 32'd0) &&
                      ({1'b0, fetch_addr} < count_q);

  always_comb begin
    instr_d = NOP;
    if (fetch_ok) instr_d = mem[fetch_addr];
  end

  // Registered fetch result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) instr_q <= NOP;
    else         instr_q <= instr_d;
  end

  assign instr_o       = instr_q;
  assign cpu_run_o     = (state_q == S_RUN);
  assign instr_count_o = count_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader (DEPTH=64).
module tb_instr_loader;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          wr_instr_en_i;
  logic [31:0]   wr_instr_i;
  logic          reload_i;
  logic [31:0]   pc_i;
  logic [31:0]   instr_o;
  logic          cpu_run_o;
  logic [AW:0]   instr_count_o;
  logic          overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  instr_loader #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wr_instr_en_i (wr_instr_en_i),
    .wr_instr_i    (wr_instr_i),
    .reload_i      (reload_i),
    .pc_i          (pc_i),
    .instr_o       (instr_o),
    .cpu_run_o     (cpu_run_o),
    .instr_count_o (instr_count_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic run, input int cnt,
                            input logic ovf);
    chk({tag, ".run"},   32'(cpu_run_o),     32'(run));
    chk({tag, ".count"}, 32'(instr_count_o), 32'(cnt));
    chk({tag, ".ovf"},   32'(overflow_o),    32'(ovf));
  endtask

  function automatic logic [31:0] wa(input int i);
    return 32'h01E0_0093 + 32'(i) * 32'h0000_0080;
  endfunction
  function automatic logic [31:0] wb(input int i);
    return 32'hB000_0000 + 32'(i) * 32'h0000_0101;
  endfunction
  function automatic logic [31:0] wc(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    rst_ni        = 1'b0;
    wr_instr_en_i = 1'b0;
    wr_instr_i    = '0;
    reload_i      = 1'b0;
    pc_i          = '0;

    // Reset values
    step();
    step();
    chk_status("reset", 1'b0, 0, 1'b0);
    chk("reset.instr", instr_o, NOP);
    rst_ni = 1'b1;

    // Idle with strobe low: stays in LOAD
    for (int i = 0; i < 10; i++) begin
      step();
      chk_status("idle", 1'b0, 0, 1'b0);
      chk("idle.instr", instr_o, NOP);
    end

    // 10-word back-to-back load
    for (int i = 0; i < 10; i++) begin
      wr_instr_en_i = 1'b1;
      wr_instr_i    = wa(i);
      step();
      chk_status("load10", 1'b0, i + 1, 1'b0);
    end
    wr_instr_en_i = 1'b0;
    step();
    chk_status("load10.exit", 1'b1, 10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      pc_i = 32'(4 * i);
      step();
      chk("load10.read", instr_o, wa(i));
    end
    pc_i = 32'd40;
    step();
    chk("load10.past_end", instr_o, NOP);

    // Reload into an empty LOAD, then 66 words into a 64-word RAM
    reload_i = 1'b1;
    pc_i     = 32'd0;
    step();
    reload_i = 1'b0;
    chk_status("reload1", 1'b0, 0, 1'b0);
    chk("reload1.last_fetch", instr_o, wa(0));
    for (int i = 0; i < 66; i++) begin
      wr_instr_en_i = 1'b1;
      wr_instr_i    = wb(i);
      step();
      if (i < 63) chk_status("full.loading", 1'b0, i + 1, 1'b0);
      else        chk_status("full.run", 1'b1, 64, 1'b0);
    end
    wr_instr_en_i = 1'b0;
    pc_i = 32'd252;
    step();
    chk("full.word64", instr_o, wb(63));
    pc_i = 32'd0;
    step();
    chk("full.word1", instr_o, wb(0));
    pc_i = 32'd256;
    step();
    chk("full.upper_bits", instr_o, NOP);
    chk_status("full.after", 1'b1, 64, 1'b0);

    // 3 words, 1-cycle pause, 2 more (ignored in RUN)
    reload_i = 1'b1;
    step();
    reload_i = 1'b0;
    chk_status("pause.reload", 1'b0, 0, 1'b0);
    chk("pause.reload_nop", instr_o, NOP);
    for (int i = 0; i < 3; i++) begin
      wr_instr_en_i = 1'b1;
      wr_instr_i    = wc(i);
      step();
    end
    wr_instr_en_i = 1'b0;
    step();
    chk_status("pause.exit", 1'b1, 3, 1'b0);
    for (int i = 3; i < 5; i++) begin
      wr_instr_en_i = 1'b1;
      wr_instr_i    = wc(i);
      step();
      chk_status("pause.ignored", 1'b1, 3, 1'b0);
    end
    wr_instr_en_i = 1'b0;
    pc_i = 32'd12;
    step();
    chk("pause.pc12", instr_o, NOP);
    pc_i = 32'd8;
    step();
    chk("pause.pc8", instr_o, wc(2));

    // Reload together with a strobe: the strobed word is dropped
    pc_i          = 32'd0;
    reload_i      = 1'b1;
    wr_instr_en_i = 1'b1;
    wr_instr_i    = 32'hDEAD_BEEF;
    step();
    reload_i = 1'b0;
    chk_status("rld_wr", 1'b0, 0, 1'b0);
    chk("rld_wr.last_fetch", instr_o, wc(0));
    wr_instr_i = 32'h1111_0001;
    step();
    chk("rld_wr.nop_after", instr_o, NOP);
    wr_instr_i = 32'h1111_0002;
    step();
    chk_status("rld_wr.loaded", 1'b0, 2, 1'b0);
    wr_instr_en_i = 1'b0;
    step();
    chk_status("rld_wr.exit", 1'b1, 2, 1'b0);
    chk("rld_wr.first_fetch_nop", instr_o, NOP);
    step();
    chk("rld_wr.pc0", instr_o, 32'h1111_0001);
    pc_i = 32'd4;
    step();
    chk("rld_wr.pc4", instr_o, 32'h1111_0002);
    pc_i = 32'd8;
    step();
    chk("rld_wr.pc8", instr_o, NOP);

    // Async reset midway through a 5-word load
    reload_i = 1'b1;
    step();
    reload_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_instr_en_i = 1'b1;
      wr_instr_i    = 32'h5555_0000 + 32'(i);
      step();
    end
    chk_status("areset.before", 1'b0, 2, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_status("areset.async", 1'b0, 0, 1'b0);
    chk("areset.instr", instr_o, NOP);
    wr_instr_en_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    chk_status("areset.idle", 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wr_instr_en_i = 1'b1;
      wr_instr_i    = wc(10 + i);
      step();
    end
    wr_instr_en_i = 1'b0;
    step();
    chk_status("fresh.exit", 1'b1, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pc_i = 32'(4 * i);
      step();
      chk("fresh.read", instr_o, wc(10 + i));
    end
    pc_i = 32'd16;
    step();
    chk("fresh.past_end", instr_o, NOP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Receive side of the CPU instruction-write port: accepts a stream of 32-bit instruction words on `wr_instr_en_i`/`wr_instr_i` and packs them into a word-addressed instruction RAM. It holds the core in a load phase until the stream ends, then releases the core and serves synchronous fetch reads to the IF stage. Addresses at or beyond the loaded program length read back as NOP.

## Interface
Parameters:
- `DEPTH`, default 64: instruction RAM depth in words; must be a power of two, at least 2.
- `AW`, default $clog2(DEPTH): word-address width, derived.

Ports:
- `clk_i` in 1: clock; all state changes on rising edge.
- `rst_ni` in 1: asynchronous reset, active-low.
- `wr_instr_en_i` in 1: write strobe; one word accepted per high cycle during LOAD.
- `wr_instr_i` in 32: instruction word written when strobe is high.
- `reload_i` in 1: single-cycle pulse; discards the program and re-enters LOAD.
- `pc_i` in 32: fetch byte address; bits [1:0] ignored.
- `instr_o` out 32: fetched instruction; registered.
- `cpu_run_o` out 1: high in RUN; the core must stall while low.
- `instr_count_o` out AW+1: number of words accepted in the current load.
- `overflow_o` out 1: sticky; a write was attempted while the RAM was full.

## Operation
- Reset values: state LOAD, write pointer 0, `instr_count_o` 0, `cpu_run_o` 0, `overflow_o` 0, `instr_o` 32'h0000_0013 (ADDI x0,x0,0). RAM contents are not reset.
- The FSM has two states:
  - LOAD:
    - Each cycle with `wr_instr_en_i`=1 and count<DEPTH: mem[count] <= `wr_instr_i`, count++.
    - With `wr_instr_en_i`=1 and count==DEPTH: word dropped, `overflow_o` <= 1.
    - Exit to RUN on the first cycle where `wr_instr_en_i`=0 and count>0.
    - Also exit to RUN on the edge that accepts the DEPTH-th word.
    - Strobe low with count==0: stay in LOAD (waiting for first word).
  - RUN:
    - `wr_instr_en_i` ignored; no RAM writes; `overflow_o` unchanged.
    - `reload_i`=1 -> LOAD, count <= 0, `overflow_o` <= 0.
- `reload_i` in LOAD: count <= 0, `overflow_o` <= 0. Any strobe in that same cycle is ignored, so reload wins.
- Fetch address is `pc_i`[AW+1:2]. Bits of `pc_i` above AW+1 must be zero for a valid fetch.
- Fetch result, registered on each edge:
  - In LOAD: `instr_o` <= NOP.
  - In RUN with word address < count and upper `pc_i` bits zero: `instr_o` <= mem[addr].
  - Otherwise: `instr_o` <= NOP.
- `cpu_run_o` is the registered state (RUN=1). `instr_count_o` is the registered count.

## Timing
- Write latency: a word strobed at edge N is readable by a fetch presented in any cycle after edge N once in RUN.
- Read latency: 1 cycle. `pc_i` sampled at edge N gives `instr_o` valid after edge N, held until the next edge.
- LOAD->RUN: strobe low sampled at edge N gives `cpu_run_o`=1 after edge N. The first fetch is the one sampled at edge N+1.
- Full exit: the DEPTH-th word accepted at edge N gives `cpu_run_o`=1 after edge N. A strobe still high at N+1 is ignored, and `overflow_o` stays 0.
- RUN->LOAD: `reload_i` at edge N gives `cpu_run_o`=0 and `instr_count_o`=0 after N. `instr_o` is NOP from edge N+1 onward.
- Async reset mid-load: all outputs return to reset values immediately. The partial program is discarded because count=0.
- Throughput: one word per cycle, back-to-back, no bubbles required.

## Test plan
- Reset then idle, strobe low 10 cycles -> `cpu_run_o`=0, `instr_count_o`=0, `instr_o`=32'h0000_0013 throughout.
- Stream 10 words back-to-back (e.g. 32'h01E00093, 32'h01E00113, ...), then drop the strobe:
  - `instr_count_o`=10; `cpu_run_o` rises the edge after the strobe falls.
  - `pc_i`=0,4,...,36 returns the words in order, each one cycle after its `pc_i`.
  - `pc_i`=40 returns NOP.
- `DEPTH`=64, 66 consecutive strobed words:
  - RUN entered after word 64; `overflow_o` stays 0; words 65-66 ignored.
  - `pc_i`=252 returns word 64.
- Strobe 3 words, pause strobe 1 cycle, strobe 2 more:
  - RUN after the pause; `instr_count_o`=3.
  - The later 2 words do not alter mem (`pc_i`=12 gives NOP).
- In RUN assert `reload_i` together with `wr_instr_en_i`, then stream 2 new words:
  - That cycle's word is dropped; `instr_count_o`=2 after reload.
  - `pc_i`=0 returns the first new word.
- Assert `rst_ni`=0 midway through a 5-word load:
  - Outputs go to reset values asynchronously.
  - A fresh 4-word load gives `instr_count_o`=4 and correct readback.
